// File: rtl/bidir_serializer_pkg.sv
// Shared definitions for the bidirectional serializer and the shift-register
// receiver it feeds: direction encodings, FSM states and a width helper.
package bidir_serializer_pkg;

  // Direction encodings; identical to the receiver's R_L_n meaning.
  localparam logic DIR_RIGHT = 1'b1;  // right shift, LSB first
  localparam logic DIR_LEFT  = 1'b0;  // left shift, MSB first

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-counter width: max(1, clog2(n)).
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serializer_bit_counter.sv
// Modulo-N bit counter with enable, synchronous clear and terminal-count flag.
// Clear has priority over enable; the count wraps from N-1 back to 0.
module serializer_bit_counter
  import bidir_serializer_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] r_cnt;

  // Count enabled ticks, wrapping at N-1; clear restarts a frame at bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/bidir_serializer.sv
// Parallel-in, serial-out transmitter for the bidirectional shift register.
// A word is latched on a valid/ready handshake and shifted out one bit per
// ser_en tick, LSB first (dir=1) or MSB first (dir=0), so the receiver shifting
// in the same direction ends up holding the original word.
//
// Handshake: a word transfers on a clk edge where in_valid && in_ready.
// in_ready is combinational from ser_en on the last bit of a frame, so the
// producer must not derive in_valid from in_ready.
module bidir_serializer
  import bidir_serializer_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           in_data,
  input  logic                   in_dir,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   ser_en,
  output logic                   ser_out,
  output logic                   ser_dir,
  output logic                   ser_valid,
  output logic                   ser_last,
  output logic                   dbg_state,
  output logic [cnt_width(N)-1:0] dbg_cnt
);

  localparam int CW = cnt_width(N);

  state_t        r_state;
  state_t        w_next_state;
  logic [N-1:0]  r_shreg;
  logic          r_dir;
  logic [CW-1:0] w_cnt;
  logic          w_tc;
  logic          w_consume;
  logic          w_ready;
  logic          w_accept;

  // A bit is consumed only in SHIFT on a ser_en edge; ser_en is ignored in IDLE.
  assign w_consume = (r_state == SHIFT) && ser_en;
  assign w_ready   = !reset && ((r_state == IDLE) || (w_consume && w_tc));
  assign w_accept  = in_valid && w_ready;

  serializer_bit_counter #(.N(N), .CW(CW)) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_consume),
    .i_clr (w_accept),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: leave IDLE on a word, return only when the last bit goes
  // without a follow-on word waiting.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = SHIFT;
      SHIFT:   if (w_consume && w_tc && !in_valid) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Shift register and latched direction. The final consuming shift empties
  // the register, so ser_out rests at 0 once the frame has drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg <= '0;
      r_dir   <= DIR_LEFT;
    end else if (w_accept) begin
      r_shreg <= in_data;
      r_dir   <= in_dir;
    end else if (w_consume) begin
      if (r_dir == DIR_RIGHT) begin
        r_shreg <= {1'b0, r_shreg[N-1:1]};
      end else begin
        r_shreg <= {r_shreg[N-2:0], 1'b0};
      end
    end
  end

  // Outputs decoded from state, counter and the shift register end bit.
  always_comb begin
    ser_valid = (r_state == SHIFT);
    ser_last  = (r_state == SHIFT) && w_tc;
    ser_out   = (r_dir == DIR_RIGHT) ? r_shreg[0] : r_shreg[N-1];
    ser_dir   = r_dir;
    in_ready  = w_ready;
    dbg_state = r_state;
    dbg_cnt   = w_cnt;
  end

endmodule

// File: tb/tb_bidir_serializer.sv
// Bench for bidir_serializer (N=4): a table of single frames plus hand-written
// sequences for rate control, back-to-back frames, input stability and reset.
module tb_bidir_serializer;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] data;
    logic         dir;
    logic [N-1:0] bits;  // bits[i] = i-th transmitted bit
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] in_data = '0;
  logic         in_dir = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         ser_en = 1'b0;
  logic         ser_out, ser_dir, ser_valid, ser_last;
  logic         dbg_state;
  logic [1:0]   dbg_cnt;

  int checks = 0;
  int failures = 0;

  logic [2:0]   exp_q[$];  // {dir, last, bit}
  logic [N-1:0] drv_bits = '0;
  logic         drv_dir = 1'b0;
  logic [N-1:0] rx = '0;
  logic [N-1:0] rx_done = '0;

  vec_t vecs[6];

  bidir_serializer #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_en    (ser_en),
    .ser_out   (ser_out),
    .ser_dir   (ser_dir),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard and receiver model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (ser_valid && ser_en) begin
        if (exp_q.size() == 0) begin
          chk("no_orphan_bit", ser_valid, 1'b0);
        end else begin
          logic [2:0] e;
          logic [N-1:0] nxt;
          e = exp_q.pop_front();
          chk("ser_out", ser_out, e[0]);
          chk("ser_last", ser_last, e[1]);
          chk("ser_dir", ser_dir, e[2]);
          nxt = ser_dir ? {ser_out, rx[N-1:1]} : {rx[N-2:0], ser_out};
          if (ser_last) begin
            rx_done = nxt;
            rx = '0;
          end else begin
            rx = nxt;
          end
        end
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < N; i++) exp_q.push_back({drv_dir, (i == N - 1), drv_bits[i]});
      end
    end
  end

  task automatic present(input vec_t v);
    in_data = v.data;
    in_dir = v.dir;
    drv_bits = v.bits;
    drv_dir = v.dir;
    in_valid = 1'b1;
  endtask

  // Drive one word and hold in_valid until it is accepted.
  task automatic send_word(input vec_t v);
    bit ok = 1'b0;
    @(posedge clk); #1;
    present(v);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("accept_timeout", ok, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || ser_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{data: 4'b1011, dir: 1'b1, bits: 4'b1011};  // 1,1,0,1
    vecs[1] = '{data: 4'b0110, dir: 1'b0, bits: 4'b0110};  // 0,1,1,0
    vecs[2] = '{data: 4'b1100, dir: 1'b0, bits: 4'b0011};  // 1,1,0,0
    vecs[3] = '{data: 4'b0011, dir: 1'b1, bits: 4'b0011};  // 1,1,0,0
    vecs[4] = '{data: 4'hA,    dir: 1'b1, bits: 4'b1010};  // 0,1,0,1
    vecs[5] = '{data: 4'h5,    dir: 1'b0, bits: 4'b1010};  // 0,1,0,1

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ser_out", ser_out, 1'b0);
    chk("rst_ser_dir", ser_dir, 1'b0);
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_ser_last", ser_last, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_state", dbg_state, 1'b0);
    chk("rst_cnt", dbg_cnt, 2'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ser_en = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 1'b1);

    // Table of single frames at full rate, checked by receiver contents too.
    for (int v = 0; v < 4; v++) begin
      send_word(vecs[v]);
      drain();
      chk("rx_word", rx_done, vecs[v].data);
    end

    // Rate control: ser_en every 3rd cycle, word 1001 LSB first.
    begin
      vec_t r;
      int nvalid = 0;
      int nlast = 0;
      logic [N-1:0] seq;
      r = '{data: 4'b1001, dir: 1'b1, bits: 4'b1001};
      seq = r.bits;
      @(posedge clk); #1;
      ser_en = 1'b0;
      present(r);
      @(negedge clk);
      chk("rate_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
        ser_en = (k % 3 == 2);
        @(negedge clk);
        if (ser_valid) nvalid++;
        if (ser_last) nlast++;
        chk("rate_last", ser_last, (k >= 9));
        chk("rate_hold", ser_out, seq[k / 3]);
        @(posedge clk); #1;
      end
      ser_en = 1'b1;
      chk("rate_valid_cycles", nvalid, 12);
      chk("rate_last_cycles", nlast, 3);
      @(negedge clk);
      chk("rate_idle", ser_valid, 1'b0);
      chk("rate_rx", rx_done, r.data);
      @(posedge clk); #1;
    end

    // Back-to-back: A (LSB first) then B (MSB first) with in_valid held.
    @(posedge clk); #1;
    present(vecs[4]);
    @(negedge clk);
    chk("b2b_ready_idle", in_ready, 1'b1);
    @(posedge clk); #1;
    present(vecs[5]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b2b_ready_a", in_ready, (k == 3));
      chk("b2b_valid_a", ser_valid, 1'b1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b2b_ready_b", in_ready, (k == 3));
      chk("b2b_valid_b", ser_valid, 1'b1);
    end
    drain();
    chk("b2b_rx", rx_done, vecs[5].data);

    // Input stability: in_data/in_dir change while the frame is in flight.
    @(posedge clk); #1;
    present(vecs[0]);
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = 4'hF;
    in_dir = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stab_ready", in_ready, (k == 3));
    end
    drain();
    chk("stab_rx", rx_done, vecs[0].data);

    // Reset mid-frame after two bits have gone out.
    @(posedge clk); #1;
    present(vecs[0]);
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    exp_q.delete();
    rx = '0;
    #1;
    chk("mid_rst_ser_out", ser_out, 1'b0);
    chk("mid_rst_ser_dir", ser_dir, 1'b0);
    chk("mid_rst_valid", ser_valid, 1'b0);
    chk("mid_rst_last", ser_last, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1'b1);
      chk("post_rst_no_bits", ser_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bidir_serializer.md
# bidir_serializer

Parallel-in, serial-out transmitter that drives the serial input of the team's bidirectional shift register. It accepts an N-bit word over a valid/ready handshake and shifts it out one bit per bit-enable tick, LSB-first or MSB-first according to a per-word direction flag. The bit order is chosen so that the receiving register holds the original word after N shifts in the same direction. It sits between a parallel producer and the serial link: ser_out drives SI, and dir drives R_L_n of the receiver.

## Interface
- N, 4: word width in bits; legal range N >= 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N  parallel word to transmit.
- in_dir  input  1  direction for this word: 1 = right shift, LSB first; 0 = left shift, MSB first.
- in_valid  input  1  producer has a word on in_data/in_dir.
- in_ready  output  1  block accepts a word this cycle.
- ser_en  input  1  bit-rate tick; the current bit is consumed on a clk edge where ser_en = 1.
- ser_out  output  1  current serial bit (to receiver SI).
- ser_dir  output  1  latched direction of the word in flight (to receiver R_L_n).
- ser_valid  output  1  ser_out carries a frame bit.
- ser_last  output  1  ser_out is bit N-1 of the frame.

## Operation
- Reset values: ser_out = 0, ser_dir = 0, ser_valid = 0, ser_last = 0, internal shift register = 0, bit counter = 0, state = IDLE. in_ready is held at 0 while reset is high.
- State machine has two states:
  - IDLE: in_ready = 1 and ser_valid = 0. If in_valid = 1, latch the word on the edge and go to SHIFT.
  - SHIFT: ser_valid = 1. On a ser_en edge, either advance one bit or end the frame.
- Load: shreg <= in_data, ser_dir <= in_dir, cnt <= 0.
- ser_out is taken directly from the shift register:
  - dir = 1: ser_out = shreg[0].
  - dir = 0: ser_out = shreg[N-1].
- Advance (SHIFT, ser_en = 1, cnt < N-1):
  - dir = 1: shreg shifts right with 0 fill.
  - dir = 0: shreg shifts left with 0 fill.
  - cnt increments.
- ser_last = ser_valid && (cnt == N-1).
- End of frame (SHIFT, ser_en = 1, cnt == N-1):
  - If in_valid = 1, reload immediately and stay in SHIFT. Back-to-back frames have zero idle bits.
  - Otherwise go to IDLE.
- in_ready = (state == IDLE) || (state == SHIFT && cnt == N-1 && ser_en). This is a combinational path from ser_en to in_ready; the producer must not make in_valid depend on in_ready.
- ser_en = 0 in SHIFT freezes every register. ser_en is ignored in IDLE.
- Changes on in_data/in_dir while a frame is in flight have no effect.
- Counter width is max(1, $clog2(N)). cnt never exceeds N-1 and has no wrap beyond it.

## Timing
- Latency: accept edge T puts bit 0 on ser_out with ser_valid = 1 after T. The first bit is visible for one full ser_en period.
- Each bit is held from one consuming ser_en edge to the next.
- A frame occupies exactly N ser_en edges. With ser_en tied high, it spans N clk cycles.
- Simultaneous last-bit consumption and in_valid: the new word's first bit appears right after the same edge. ser_valid stays 1 and ser_last drops to 0.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). The partial frame is discarded and is not resumed after reset release.
- First accept after reset is possible on the first clk edge with reset low.

## Structure
- Shared package holds DIR_RIGHT = 1'b1 and DIR_LEFT = 1'b0, which are also used by the shift-register block, plus the state enum (IDLE, SHIFT).
- One sub-module: serializer_bit_counter. It is a parameterised modulo-N counter with enable, clear and a terminal-count output.
- The shift register and FSM stay in the top module.

## Test plan
- Reset mid-frame: N=4, dir=1, word 4'b1011, ser_en=1; assert reset after 2 bits -> outputs 0 immediately; after release in_ready=1 and no residual bits appear.
- LSB-first frame: N=4, word 4'b1011, dir=1, ser_en=1 -> ser_out = 1,1,0,1; ser_last only on the 4th bit; ser_dir=1 throughout; a bidirectional register with R_L_n=1 then holds 1011.
- MSB-first frame: N=4, word 4'b0110, dir=0 -> ser_out = 0,1,1,0; a receiver with R_L_n=0 then holds 0110.
- Rate control: ser_en pulses every 3rd cycle, word 4'b1001, dir=1 -> each bit is held 3 cycles; ser_valid stays high for 12 cycles; ser_last is high for the final 3 cycles.
- Back-to-back: words A=4'hA (dir=1) and B=4'h5 (dir=0), in_valid held high, ser_en=1 -> 8 contiguous valid bits 0,1,0,1,0,1,0,1; ser_dir switches at the boundary; in_ready pulses only on the last-bit cycles.
- Input stability: change in_data to 4'hF during a frame -> transmitted bits are unchanged; in_ready=0 until the last bit is consumed.
